// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: the receiver FSM state
// encoding and the number of data bits per frame (fixed 8N1 framing).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,       // waiting for a falling edge on the synchronized line
    START,      // counting to the middle of the start bit
    DATA,       // sampling the eight data bits, LSB first
    STOP,       // sampling the stop bit
    WAIT_IDLE   // framing error seen; wait for the line to return high
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit. Both flops advance only
// on clock-enabled cycles and reset to 1, matching an idle-high serial line.
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous reset, active low
//   ce   in   clock enable
//   d    in   asynchronous input
//   q    out  synchronized output
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs before either updates; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else if (ce) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// -----------------------------------------------------------------------------
// uart_rx_unit
// Serial-to-parallel UART receiver, 8N1. The line is synchronized, the start
// bit is confirmed at its midpoint, and every following bit is sampled one bit
// period after the previous sample. Each correctly framed byte appears on po
// together with a one-cycle dv strobe.
//
// Parameters:
//   CLKS_PER_BIT    enabled clock cycles per serial bit (>= 4)
//   CLKS_PER_BIT_W  width of the bit counter (must hold CLKS_PER_BIT-1)
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous reset, active low (acts regardless of ce)
//   ce   in   clock enable for all state, synchronizer included
//   di   in   asynchronous serial input, idle high
//   dv   out  data-valid strobe, exactly one clk cycle wide
//   po   out  received byte, bit 0 is the first data bit on the line
// -----------------------------------------------------------------------------
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 50,
  parameter int CLKS_PER_BIT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       di,
  output logic       dv,
  output logic [7:0] po
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CLKS_PER_BIT_W-1:0] HALF_LAST = CLKS_PER_BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CLKS_PER_BIT_W-1:0] FULL_LAST = CLKS_PER_BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]          IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic                      s;
  rx_state_t                 state, state_d;
  logic [CLKS_PER_BIT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0]          idx, idx_d;
  logic [7:0]                shreg, shreg_d;
  logic [7:0]                po_d;
  logic                      dv_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   (di),
    .q   (s)
  );

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shreg_d = shreg;
    po_d    = po;
    dv_d    = 1'b0;

    case (state)
      IDLE: begin
        if (!s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_d = s ? IDLE : DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_d        = '0;
          shreg_d[idx] = s;
          if (idx == IDX_LAST) state_d = STOP;
          else                 idx_d   = idx + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_d = '0;
          if (s) begin
            po_d    = shreg;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            // Framing error: drop the byte and wait out the low line so a
            // held-low input cannot start a phantom frame.
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      WAIT_IDLE: begin
        if (s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      po    <= '0;
      dv    <= 1'b0;
    end else begin
      // dv must last one clk cycle even when ce is sparse, so it is cleared
      // on every edge and only set on enabled ones.
      dv <= ce & dv_d;
      if (ce) begin
        state <= state_d;
        cnt   <= cnt_d;
        idx   <= idx_d;
        shreg <= shreg_d;
        po    <= po_d;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_unit
// Directed bench for uart_rx_unit with default parameters (50 cycles/bit,
// 2 ns clock, 100 ns bit time). A monitor logs every dv pulse with the byte
// on po; the stimulus sequence compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_rx_unit;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b1;
  logic       di  = 1'b1;
  logic       dv;
  logic [7:0] po;

  // ce control: ce_div alternates ce every clk cycle, ce_freeze forces it low.
  logic ce_div    = 1'b0;
  logic ce_freeze = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // dv monitor
  int         dv_pulses = 0;
  int         dv_high   = 0;
  logic       dv_prev   = 1'b0;
  realtime    dv_t      = 0.0;
  logic [7:0] po_log[$];

  uart_rx_unit #(
    .CLKS_PER_BIT   (50),
    .CLKS_PER_BIT_W (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .di  (di),
    .dv  (dv),
    .po  (po)
  );

  always #1 clk = ~clk;

  always @(negedge clk) begin
    if (ce_freeze)   ce = 1'b0;
    else if (ce_div) ce = ~ce;
    else             ce = 1'b1;
  end

  always @(negedge clk) begin
    if (dv === 1'b1) begin
      dv_high++;
      if (dv_prev !== 1'b1) begin
        dv_pulses++;
        dv_t = $realtime;
        po_log.push_back(po);
      end
    end
    dv_prev = dv;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int bit_ns);
    di = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      di = data[i];
      #(bit_ns);
    end
    di = stop;
    #(bit_ns);
  endtask

  initial begin
    int      pulses0;
    int      base;
    realtime t0;
    realtime lat;

    // All input changes happen on falling clock edges (even ns times).
    @(negedge clk);

    // ---------------- reset, with di toggling ----------------
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      di = i[0];
      #2;
    end
    check("rst_dv", {31'd0, dv}, 32'd0);
    check("rst_po", {24'd0, po}, 32'h00);
    di = 1'b1;
    #2;
    rst = 1'b1;
    #200;
    check("rst_pulses", dv_pulses, 0);
    check("rst_state", dut.state, IDLE);
    check("rst_po_after", {24'd0, po}, 32'h00);

    // ---------------- valid frame 0x55 ----------------
    pulses0 = dv_pulses;
    t0 = $realtime;
    send_frame(8'h55, 1'b1, 100);
    #100;
    check("v55_pulses", dv_pulses - pulses0, 1);
    check("v55_po", {24'd0, po}, 32'h55);
    check("v55_width", dv_high, dv_pulses);
    lat = dv_t - t0;
    check("v55_latency", {31'd0, (lat >= 940.0 && lat <= 970.0)}, 32'd1);

    // ---------------- framing error, then held low ----------------
    pulses0 = dv_pulses;
    send_frame(8'h55, 1'b0, 100);
    di = 1'b0;
    #4000;
    check("ferr_pulses", dv_pulses - pulses0, 0);
    check("ferr_po", {24'd0, po}, 32'h55);
    check("ferr_state", dut.state, WAIT_IDLE);
    di = 1'b1;
    #200;
    send_frame(8'hA3, 1'b1, 100);
    #100;
    check("a3_pulses", dv_pulses - pulses0, 1);
    check("a3_po", {24'd0, po}, 32'hA3);

    // ---------------- glitch ----------------
    pulses0 = dv_pulses;
    di = 1'b0;
    #20;
    di = 1'b1;
    #300;
    check("glitch_pulses", dv_pulses - pulses0, 0);
    check("glitch_state", dut.state, IDLE);
    check("glitch_po", {24'd0, po}, 32'hA3);
    send_frame(8'h3C, 1'b1, 100);
    #100;
    check("post_glitch_pulses", dv_pulses - pulses0, 1);
    check("post_glitch_po", {24'd0, po}, 32'h3C);

    // ---------------- back-to-back 0x00, 0xFF ----------------
    base = po_log.size();
    send_frame(8'h00, 1'b1, 100);
    send_frame(8'hFF, 1'b1, 100);
    #100;
    check("b2b_count", po_log.size() - base, 2);
    if (po_log.size() >= base + 2) begin
      check("b2b_first", {24'd0, po_log[base]}, 32'h00);
      check("b2b_second", {24'd0, po_log[base + 1]}, 32'hFF);
    end
    check("b2b_po", {24'd0, po}, 32'hFF);

    // ---------------- ce every 2nd cycle, 200 ns bit ----------------
    ce_div = 1'b1;
    #20;
    pulses0 = dv_pulses;
    send_frame(8'h55, 1'b1, 200);
    #200;
    check("ce_pulses", dv_pulses - pulses0, 1);
    check("ce_po", {24'd0, po}, 32'h55);
    check("ce_width", dv_high, dv_pulses);
    ce_div = 1'b0;
    #20;

    // ---------------- ce frozen mid-frame, 0xC6 ----------------
    pulses0 = dv_pulses;
    di = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) begin
      di = 8'hC6 >> i;
      #100;
    end
    di = 1'b0;               // bit 4 of 0xC6
    #30;
    ce_freeze = 1'b1;
    #250;
    check("frz_state", dut.state, DATA);
    check("frz_idx", {29'd0, dut.idx}, 32'd4);
    #250;
    ce_freeze = 1'b0;
    #70;
    di = 1'b0; #100;         // bit 5
    di = 1'b1; #100;         // bit 6
    di = 1'b1; #100;         // bit 7
    di = 1'b1; #100;         // stop
    #100;
    check("frz_pulses", dv_pulses - pulses0, 1);
    check("frz_po", {24'd0, po}, 32'hC6);

    // ---------------- reset mid-frame ----------------
    pulses0 = dv_pulses;
    di = 1'b0;
    #300;
    rst = 1'b0;
    #10;
    rst = 1'b1;
    di = 1'b1;
    #1200;
    check("rstmid_pulses", dv_pulses - pulses0, 0);
    check("rstmid_po", {24'd0, po}, 32'h00);
    check("rstmid_state", dut.state, IDLE);
    send_frame(8'h81, 1'b1, 100);
    #100;
    check("rstmid_next_po", {24'd0, po}, 32'h81);
    check("final_width", dv_high, dv_pulses);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_unit.md
# uart_rx_unit

Serial-to-parallel UART receiver, fixed 8N1 framing (1 start, 8 data LSB-first, 1 stop, no parity). Oversamples the asynchronous line `di` with a clock-enable-qualified bit counter and presents each correctly framed byte on `po` with a one-cycle `dv` strobe. Sits between the external serial pin and the byte-level command/MIDI parser of the synth.

## Interface
- `CLKS_PER_BIT`, 50: enabled clock cycles per serial bit; must be ≥ 4.
- `CLKS_PER_BIT_W`, 6: bit counter width; must hold `CLKS_PER_BIT-1`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, synchronous, active-low; one clock, no other clock domains.
- `ce` in 1: clock enable; all state, including the synchronizer, advances only on cycles with `ce=1`.
- `di` in 1: asynchronous serial input, idle high.
- `dv` out 1: data-valid strobe.
- `po` out 8: received byte, bit 0 = first data bit on the line.

## Operation
- `di` passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized line `s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Counter `cnt` (CLKS_PER_BIT_W bits), bit index (3 bits), 8-bit shift register.
- IDLE: `s=0` → START, `cnt=0`.
- START: count to `CLKS_PER_BIT/2 - 1` (floor), then sample `s`. If 0 → DATA, `cnt=0`, index 0. If 1 → IDLE (glitch rejected, nothing reported).
- DATA: count to `CLKS_PER_BIT-1`, then sample `s` into shift register at current index, `cnt=0`. After index 7 → STOP.
- STOP: count to `CLKS_PER_BIT-1`, then sample. If 1: `po` ← shift register, `dv` ← 1, → IDLE. If 0 (framing error): no `dv`, `po` unchanged, → WAIT_IDLE.
- WAIT_IDLE: stay until `s=1`, then → IDLE. A held-low line never produces a spurious frame.
- `ce=0`: every register holds, except `dv` (see Timing).
- Reset (`rst=0` at a rising edge, regardless of `ce`): state IDLE, `cnt=0`, index 0, shift register 0, synchronizer 1, `po=8'h00`, `dv=0`. Reset mid-frame discards the partial byte.

## Timing
- Sampling at mid-bit: start bit at `CLKS_PER_BIT/2` enabled cycles after the falling edge is seen on `s`. Each data bit and the stop bit are sampled `CLKS_PER_BIT` cycles after the previous sample.
- `dv` is high for exactly one `clk` cycle. It is cleared on the next rising edge whether or not `ce` is high.
- `po` updates on the same edge that sets `dv` and holds until the next valid frame.
- Latency from the line falling edge to `dv`: 2 (sync) + 1 (edge detect) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` enabled cycles, ±1.
- Receiver re-arms in IDLE right after the stop sample. A start bit that begins at the end of the stop bit is caught (tolerates back-to-back frames).

## Structure
- Shared package `uart_pkg`: FSM state enum, `UART_DATA_BITS = 8` constant.
- One natural sub-module: `sync_2ff` (2-flop synchronizer with enable and reset value 1). Everything else stays in one file.

## Test plan
Default parameters, clk period 2 ns, bit time 100 ns, `ce=1` unless stated.
- **Reset:** hold `rst=0` for several cycles → `dv=0`, `po=8'h00`. `di` toggling during reset has no effect.
- **Valid frame:** start, data bits 1,0,1,0,1,0,1,0, stop=1 → exactly one `dv` pulse of one cycle, `po=8'h55`, about 950 ns after the start edge.
- **Framing error:** same data with stop=0, then line held low for 4 µs → no `dv`, `po` stays `8'h55`. After the line returns high, a valid `8'hA3` frame is received normally.
- **Glitch:** `di` low for 20 ns then high → no `dv`, FSM back in IDLE, and the following frame is received correctly.
- **Back-to-back:** frames `8'h00`, `8'hFF` with no idle gap → two `dv` pulses, `po` values in order.
- **Clock enable:** `ce` active every 2nd cycle with bit time 200 ns → `8'h55` received. `dv` still lasts one `clk` cycle. `ce=0` mid-frame freezes the FSM, and reception resumes correctly when `ce` returns.
